// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, initiator FSM states and the
// default bus widths used by the register responders.
package axi_lite_pkg;

  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ADDR_WIDTH = 9;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_RSP
  } axi_m_state_t;

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// Per-transaction watchdog: counts enabled cycles since the last clear and
// flags the cycle on which the budget of TIMEOUT_CYCLES is used up.
module axi_lite_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates so a late handshake that outlives the budget still aborts on the next cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns cmd_* requests into AXI
// transactions and returns one rsp_* per command, with a timeout abort.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int C_M_AXI_ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  axi_m_state_t state, state_d;

  logic                            cmd_ready_d, awvalid_d, wvalid_d, bready_d;
  logic                            arvalid_d, rready_d, rsp_valid_d, rsp_timeout_d;
  logic                            aw_done, w_done, aw_done_d, w_done_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_d, araddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_d, rsp_rdata_d;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_d;
  logic [1:0]                      rsp_resp_d;
  logic                            accept, abort, expired, timer_en;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  assign timer_en = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                    (state == ST_RD_REQ) || (state == ST_RD_RESP);

  axi_lite_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (timer_en),
    .expired(expired)
  );

  // Next-state and next-value of every registered output; handshakes take priority over expiry.
  always_comb begin
    state_d       = state;
    cmd_ready_d   = cmd_ready;
    awaddr_d      = M_AXI_AWADDR;
    awvalid_d     = M_AXI_AWVALID;
    wdata_d       = M_AXI_WDATA;
    wstrb_d       = M_AXI_WSTRB;
    wvalid_d      = M_AXI_WVALID;
    bready_d      = M_AXI_BREADY;
    araddr_d      = M_AXI_ARADDR;
    arvalid_d     = M_AXI_ARVALID;
    rready_d      = M_AXI_RREADY;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_resp_d    = rsp_resp;
    rsp_timeout_d = rsp_timeout;
    aw_done_d     = aw_done;
    w_done_d      = w_done;
    accept        = 1'b0;
    abort         = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept      = 1'b1;
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            state_d   = ST_WR_REQ;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = ST_RD_REQ;
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR_REQ: begin
        awvalid_d = M_AXI_AWVALID && !M_AXI_AWREADY;
        wvalid_d  = M_AXI_WVALID && !M_AXI_WREADY;
        aw_done_d = aw_done || (M_AXI_AWVALID && M_AXI_AWREADY);
        w_done_d  = w_done || (M_AXI_WVALID && M_AXI_WREADY);
        if (aw_done_d && w_done_d) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BREADY && M_AXI_BVALID) begin
          state_d       = ST_RSP;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = M_AXI_BRESP;
          rsp_timeout_d = 1'b0;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          state_d   = ST_RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_RD_RESP: begin
        if (M_AXI_RREADY && M_AXI_RVALID) begin
          state_d       = ST_RSP;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = M_AXI_RDATA;
          rsp_resp_d    = M_AXI_RRESP;
          rsp_timeout_d = 1'b0;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d       = ST_RSP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b1;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_timeout   <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
    end else begin
      state         <= state_d;
      cmd_ready     <= cmd_ready_d;
      M_AXI_AWADDR  <= awaddr_d;
      M_AXI_AWVALID <= awvalid_d;
      M_AXI_WDATA   <= wdata_d;
      M_AXI_WSTRB   <= wstrb_d;
      M_AXI_WVALID  <= wvalid_d;
      M_AXI_BREADY  <= bready_d;
      M_AXI_ARADDR  <= araddr_d;
      M_AXI_ARVALID <= arvalid_d;
      M_AXI_RREADY  <= rready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_resp      <= rsp_resp_d;
      rsp_timeout   <= rsp_timeout_d;
      aw_done       <= aw_done_d;
      w_done        <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a configurable AXI4-Lite responder
// model; responses are checked through an expectation queue by a separate monitor.
module tb_axi_lite_master;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
  logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]    M_AXI_WSTRB;
  logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
  logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic          M_AXI_RVALID, M_AXI_RREADY;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   rsp_count  = 0;

  int   aw_lag   = 0;
  bit   early_b  = 0;
  bit   b_hold   = 0;
  bit   ar_never = 0;
  logic [31:0] mem [0:127];

  axi_lite_master #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .M_AXI_AWADDR (M_AXI_AWADDR),
    .M_AXI_AWPROT (M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA  (M_AXI_WDATA),
    .M_AXI_WSTRB  (M_AXI_WSTRB),
    .M_AXI_WVALID (M_AXI_WVALID),
    .M_AXI_WREADY (M_AXI_WREADY),
    .M_AXI_BRESP  (M_AXI_BRESP),
    .M_AXI_BVALID (M_AXI_BVALID),
    .M_AXI_BREADY (M_AXI_BREADY),
    .M_AXI_ARADDR (M_AXI_ARADDR),
    .M_AXI_ARPROT (M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA  (M_AXI_RDATA),
    .M_AXI_RRESP  (M_AXI_RRESP),
    .M_AXI_RVALID (M_AXI_RVALID),
    .M_AXI_RREADY (M_AXI_RREADY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command, waits for acceptance, and returns in the first cycle after the accepting edge.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                               input bit expect_rsp, input logic [31:0] e_rdata,
                               input logic [1:0] e_resp, input logic e_to);
    int n = 0;
    exp_t e;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    checkOutput("cmd_accept_wait", 64'(cmd_ready), 64'd1);
    if (expect_rsp) begin
      e.rdata = e_rdata;
      e.resp  = e_resp;
      e.to    = e_to;
      exp_q.push_back(e);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input int target);
    int n = 0;
    while (rsp_count < target && n < 200) begin
      step();
      n++;
    end
    checkOutput("rsp_count", 64'(rsp_count), 64'(target));
  endtask

  // Responder model: reacts at the falling edge to what the DUT sampled at the last rising edge.
  initial begin
    bit awv_s = 0, wv_s = 0, bry_s = 0, arv_s = 0, rry_s = 0;
    logic [AW-1:0] awaddr_s = '0, araddr_s = '0, wr_addr = '0;
    logic [31:0] wdata_s = '0, wr_data = '0;
    bit got_aw = 0, got_w = 0;
    int aw_wait = 0;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_0002;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    forever begin
      @(negedge clk);
      aw_hs = awv_s && M_AXI_AWREADY;
      w_hs  = wv_s && M_AXI_WREADY;
      b_hs  = bry_s && M_AXI_BVALID;
      ar_hs = arv_s && M_AXI_ARREADY;
      r_hs  = rry_s && M_AXI_RVALID;
      if (b_hs) M_AXI_BVALID = 0;
      if (r_hs) M_AXI_RVALID = 0;
      if (aw_hs) begin got_aw = 1; wr_addr = awaddr_s; M_AXI_AWREADY = 0; aw_wait = 0; end
      if (w_hs) begin got_w = 1; wr_data = wdata_s; M_AXI_WREADY = 0; end
      if (ar_hs) begin
        M_AXI_ARREADY = 0;
        M_AXI_RVALID  = 1;
        M_AXI_RDATA   = mem[araddr_s[8:2]];
        M_AXI_RRESP   = 2'b00;
      end
      if (got_aw && got_w) begin
        got_aw = 0;
        got_w  = 0;
        mem[wr_addr[8:2]] = wr_data;
        if (!b_hold) M_AXI_BVALID = 1;
      end
      if (early_b && M_AXI_AWVALID && !M_AXI_BVALID) begin
        M_AXI_BVALID = 1;
        early_b = 0;
      end
      if (M_AXI_AWVALID && !M_AXI_AWREADY) begin
        if (aw_wait >= aw_lag) M_AXI_AWREADY = 1;
        else aw_wait++;
      end
      if (M_AXI_WVALID && !M_AXI_WREADY) M_AXI_WREADY = 1;
      if (M_AXI_ARVALID && !M_AXI_ARREADY && !ar_never) M_AXI_ARREADY = 1;
      awv_s = M_AXI_AWVALID; wv_s = M_AXI_WVALID; bry_s = M_AXI_BREADY;
      arv_s = M_AXI_ARVALID; rry_s = M_AXI_RREADY;
      awaddr_s = M_AXI_AWADDR; wdata_s = M_AXI_WDATA; araddr_s = M_AXI_ARADDR;
    end
  end

  // Response monitor: compares each consumed response against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_rsp", 64'(rsp_count), 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          checkOutput("rsp_resp", 64'(rsp_resp), 64'(e.resp));
          checkOutput("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        end
      end
    end
  end

  initial begin
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;

    $display("[TB] reset state");
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, rsp_valid}), 64'd0);
    checkOutput("rst_readies", 64'({M_AXI_BREADY, M_AXI_RREADY}), 64'd0);
    checkOutput("rst_rsp", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'd0);
    checkOutput("rst_addr", 64'({M_AXI_AWADDR, M_AXI_ARADDR}), 64'd0);

    $display("[TB] zero-wait write");
    applyStimulus(1, 9'h004, 32'hA5A5_0001, 1, 32'h0, 2'b00, 0);
    checkOutput("wr_c1_aw_w", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 64'b110);
    checkOutput("wr_c1_awaddr", 64'(M_AXI_AWADDR), 64'h004);
    checkOutput("wr_c1_wdata", 64'(M_AXI_WDATA), 64'hA5A5_0001);
    step();
    checkOutput("wr_c2_bready", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 64'b001);
    step();
    checkOutput("wr_c3_rsp_valid", 64'(rsp_valid), 64'd1);
    waitRsp(1);

    $display("[TB] read back debug register");
    applyStimulus(0, 9'h004, 32'h0, 1, 32'hA5A5_0001, 2'b00, 0);
    waitRsp(2);

    $display("[TB] zero-wait read of busy bit");
    applyStimulus(0, 9'h000, 32'h0, 1, 32'h0000_0002, 2'b00, 0);
    checkOutput("rd_c1_arvalid", 64'({M_AXI_ARVALID, M_AXI_RREADY}), 64'b10);
    step();
    checkOutput("rd_c2_rready", 64'({M_AXI_ARVALID, M_AXI_RREADY}), 64'b01);
    step();
    checkOutput("rd_c3_rsp_valid", 64'(rsp_valid), 64'd1);
    waitRsp(3);

    $display("[TB] write with lagging AWREADY and early BVALID");
    aw_lag = 3;
    early_b = 1;
    applyStimulus(1, 9'h008, 32'h1234_5678, 1, 32'h0, 2'b00, 0);
    checkOutput("lag_c1", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 64'b110);
    for (int c = 2; c <= 4; c++) begin
      step();
      checkOutput($sformatf("lag_c%0d", c), 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 64'b100);
    end
    step();
    checkOutput("lag_c5", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 64'b001);
    step();
    checkOutput("lag_c6_rsp_valid", 64'(rsp_valid), 64'd1);
    waitRsp(4);
    aw_lag = 0;
    repeat (4) step();
    checkOutput("lag_single_rsp", 64'(rsp_count), 64'd4);

    $display("[TB] read timeout");
    ar_never = 1;
    applyStimulus(0, 9'h010, 32'h0, 1, 32'h0, 2'b10, 1);
    checkOutput("to_c1_arvalid", 64'(M_AXI_ARVALID), 64'd1);
    repeat (15) step();
    checkOutput("to_c16_arvalid", 64'({M_AXI_ARVALID, rsp_valid}), 64'b10);
    step();
    checkOutput("to_c17_arvalid", 64'({M_AXI_ARVALID, rsp_valid}), 64'b01);
    waitRsp(5);
    ar_never = 0;

    $display("[TB] response backpressure");
    rsp_ready = 0;
    applyStimulus(1, 9'h00C, 32'hDEAD_BEEF, 1, 32'h0, 2'b00, 0);
    step();
    step();
    cmd_write = 0;
    cmd_addr  = 9'h00C;
    cmd_valid = 1;
    exp_q.push_back('{rdata: 32'hDEAD_BEEF, resp: 2'b00, to: 1'b0});
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp_hold%0d", c), 64'({cmd_ready, rsp_valid, rsp_resp, rsp_timeout}), 64'b01000);
      step();
    end
    rsp_ready = 1;
    step();
    checkOutput("bp_release", 64'({cmd_ready, rsp_valid}), 64'b10);
    checkOutput("bp_rsp_count", 64'(rsp_count), 64'd6);
    step();
    cmd_valid = 0;
    checkOutput("bp_second_accept", 64'(M_AXI_ARVALID), 64'd1);
    waitRsp(7);

    $display("[TB] reset during write response");
    b_hold = 1;
    applyStimulus(1, 9'h020, 32'h5555_AAAA, 0, 32'h0, 2'b00, 0);
    step();
    checkOutput("rst_wr_resp_bready", 64'(M_AXI_BREADY), 64'd1);
    rst = 1;
    step();
    rst = 0;
    checkOutput("midrst_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, rsp_valid}), 64'd0);
    checkOutput("midrst_readies", 64'({M_AXI_BREADY, M_AXI_RREADY, cmd_ready}), 64'b001);
    b_hold = 0;
    repeat (4) step();
    checkOutput("midrst_no_rsp", 64'(rsp_count), 64'd7);
    applyStimulus(0, 9'h004, 32'h0, 1, 32'hA5A5_0001, 2'b00, 0);
    waitRsp(8);

    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
